// File: rtl/pe_ctx_sequencer.sv
// Config loader and context sequencer for a row of PEs: stores NUM_CTX x NUM_PE
// control words, then replays one context per cycle. Optional `stall` input via PE_SEQ_STALL_EN.
module pe_ctx_sequencer #(
    parameter  int NUM_PE  = 4,
    parameter  int NUM_CTX = 4,
    localparam int CTX_W   = $clog2(NUM_CTX),
    localparam int WORD_W  = $clog2(NUM_CTX * NUM_PE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [7:0]            cfg_data,
    input  logic                  cfg_clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic [7:0]            iter_count,
`ifdef PE_SEQ_STALL_EN
    input  logic                  stall,
`endif
    output logic                  pe_en,
    output logic [8*NUM_PE-1:0]   pe_ctrl,
    output logic [CTX_W-1:0]      ctx_idx,
    output logic                  out_valid,
    output logic                  done,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {S_LOAD = 2'd0, S_READY = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_cnt;
    logic [7:0]        pass_cnt;
    logic [7:0]        iter_q;
    logic [7:0]        store_mem [NUM_CTX*NUM_PE];
    logic              stall_i;
    logic              word_acc;
    logic              last_word;
    logic              last_ctx;
    logic              last_pass;
    logic              start_ok;

`ifdef PE_SEQ_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    // Config stream: a word transfers on any cycle where cfg_valid and cfg_ready
    // are both high; cfg_valid is ignored while cfg_ready is low.
    assign word_acc  = cfg_valid & cfg_ready;
    assign last_word = (word_cnt == WORD_W'(NUM_CTX * NUM_PE - 1));
    assign last_ctx  = (ctx_idx == CTX_W'(NUM_CTX - 1));
    assign last_pass = (pass_cnt == iter_q - 8'd1);
    assign start_ok  = start & (iter_count != 8'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (word_acc && last_word) state_d = S_READY;
            S_READY: begin
                if (cfg_clear)     state_d = S_LOAD;
                else if (start_ok) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop)                                  state_d = S_DRAIN;
                else if (!stall_i && last_ctx && last_pass) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_READY;
            default: state_d = S_LOAD;
        endcase
    end

    assign cfg_ready = (state_q == S_LOAD);
    assign pe_en     = (state_q == S_RUN) & ~stall_i;
    assign done      = (state_q == S_DRAIN);
    assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign state_dbg = state_q;

    always_comb begin
        pe_ctrl = '0;
        if (pe_en) begin
            for (int p = 0; p < NUM_PE; p++) begin
                pe_ctrl[8*p +: 8] = store_mem[WORD_W'(int'(ctx_idx) * NUM_PE + p)];
            end
        end
    end

    // Store is written in ctx-major order straight from the word counter.
    always_ff @(posedge clock) begin
        if (word_acc) store_mem[word_cnt] <= cfg_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_LOAD;
            word_cnt  <= '0;
            ctx_idx   <= '0;
            pass_cnt  <= '0;
            iter_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= pe_en;
            case (state_q)
                S_LOAD: begin
                    if (word_acc) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                end
                S_READY: begin
                    if (cfg_clear) begin
                        word_cnt <= '0;
                    end else if (start_ok) begin
                        iter_q   <= iter_count;
                        ctx_idx  <= '0;
                        pass_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // Leaving RUN parks the index at 0 so DRAIN and READY show context 0.
                    if (state_d == S_DRAIN) begin
                        ctx_idx <= '0;
                    end else if (!stall_i) begin
                        ctx_idx <= last_ctx ? '0 : ctx_idx + 1'b1;
                        if (last_ctx) pass_cnt <= pass_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    ctx_idx  <= '0;
                    pass_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed table-driven bench for pe_ctx_sequencer (NUM_PE=4, NUM_CTX=4),
// with hand-written sequences for stall and reset-during-replay.
module tb_pe_ctx_sequencer;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        st;
    logic        sp;
    logic [7:0]  it;
    logic        sl;
    logic        e_rdy;
    logic        e_en;
    logic [31:0] e_ctrl;
    logic [1:0]  e_idx;
    logic        e_ov;
    logic        e_dn;
    logic        e_bsy;
    logic [1:0]  e_st;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic        cfg_clear;
  logic        start;
  logic        stop;
  logic [7:0]  iter_count;
  logic        stall;
  logic        pe_en;
  logic [31:0] pe_ctrl;
  logic [1:0]  ctx_idx;
  logic        out_valid;
  logic        done;
  logic        busy;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  logic [31:0] rows  [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] rows2 [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

  pe_ctx_sequencer #(.NUM_PE(4), .NUM_CTX(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_clear  (cfg_clear),
    .start      (start),
    .stop       (stop),
    .iter_count (iter_count),
`ifdef PE_SEQ_STALL_EN
    .stall      (stall),
`endif
    .pe_en      (pe_en),
    .pe_ctrl    (pe_ctrl),
    .ctx_idx    (ctx_idx),
    .out_valid  (out_valid),
    .done       (done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mkv(logic v, logic [7:0] d, logic clr, logic st, logic sp,
                               logic [7:0] it, logic sl, logic rdy, logic en,
                               logic [31:0] ctrl, logic [1:0] idx, logic ov, logic dn,
                               logic bsy, logic [1:0] s);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.st = st; r.sp = sp; r.it = it; r.sl = sl;
    r.e_rdy = rdy; r.e_en = en; r.e_ctrl = ctrl; r.e_idx = idx; r.e_ov = ov;
    r.e_dn = dn; r.e_bsy = bsy; r.e_st = s;
    return r;
  endfunction

  function automatic vec_t v_load(logic [7:0] d, logic st, logic sp);
    return mkv(1'b1, d, 1'b0, st, sp, 8'd2, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, ST_LOAD);
  endfunction

  function automatic vec_t v_ready(logic v, logic clr, logic st, logic sp, logic [7:0] it);
    return mkv(v, 8'hAA, clr, st, sp, it, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, ST_READY);
  endfunction

  function automatic vec_t v_run(logic [1:0] idx, logic [31:0] row, logic ov, logic sp, logic cv, logic st);
    return mkv(cv, 8'hEE, 1'b0, st, sp, 8'd3, 1'b0, 1'b0, 1'b1, row, idx, ov, 1'b0, 1'b1, ST_RUN);
  endfunction

  function automatic vec_t v_drain();
    return mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, ST_DRAIN);
  endfunction

  // scoreboard
  task automatic check(string name, int n, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // driver: apply inputs, compare outputs at the falling edge, then advance one cycle
  task automatic run_cycle(vec_t v, int n);
    cfg_valid  = v.v;
    cfg_data   = v.d;
    cfg_clear  = v.clr;
    start      = v.st;
    stop       = v.sp;
    iter_count = v.it;
    stall      = v.sl;
    @(negedge clock);
    check("cfg_ready", n, 32'(cfg_ready), 32'(v.e_rdy));
    check("pe_en",     n, 32'(pe_en),     32'(v.e_en));
    check("pe_ctrl",   n, pe_ctrl,        v.e_ctrl);
    check("ctx_idx",   n, 32'(ctx_idx),   32'(v.e_idx));
    check("out_valid", n, 32'(out_valid), 32'(v.e_ov));
    check("done",      n, 32'(done),      32'(v.e_dn));
    check("busy",      n, 32'(busy),      32'(v.e_bsy));
    check("state",     n, 32'(state_dbg), 32'(v.e_st));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h0; cfg_clear = 1'b0;
    start = 1'b0; stop = 1'b0; iter_count = 8'd0; stall = 1'b0;

    // first load with a stray start and stop that must be ignored
    for (int i = 0; i < 16; i++) vecs.push_back(v_load(8'(i), i == 5, i == 7));
    vecs.push_back(v_ready(1'b1, 1'b0, 1'b1, 1'b0, 8'd0));  // start with iter 0 ignored
    vecs.push_back(v_ready(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd2));
    for (int k = 0; k < 8; k++) vecs.push_back(v_run(2'(k % 4), rows[k % 4], k > 0, 1'b0, k == 2, k == 3));
    vecs.push_back(v_drain());
    // stop at the third RUN cycle of a 5-pass replay
    vecs.push_back(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd5));
    for (int k = 0; k < 3; k++) vecs.push_back(v_run(2'(k), rows[k], k > 0, k == 2, 1'b0, 1'b0));
    vecs.push_back(v_drain());
    // replay again without reload
    vecs.push_back(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
    for (int k = 0; k < 4; k++) vecs.push_back(v_run(2'(k), rows[k], k > 0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(v_drain());
    vecs.push_back(v_ready(1'b0, 1'b1, 1'b1, 1'b0, 8'd3));  // clear beats start
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, ST_LOAD));
    for (int i = 0; i < 16; i++) vecs.push_back(v_load(8'h10 + 8'(i), 1'b0, 1'b0));
    vecs.push_back(v_ready(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));

    @(posedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_cfg_ready", -1, 32'(cfg_ready), 32'd1);
    check("rst_pe_en",     -1, 32'(pe_en),     32'd0);
    check("rst_pe_ctrl",   -1, pe_ctrl,        32'd0);
    check("rst_ctx_idx",   -1, 32'(ctx_idx),   32'd0);
    check("rst_out_valid", -1, 32'(out_valid), 32'd0);
    check("rst_done",      -1, 32'(done),      32'd0);
    check("rst_busy",      -1, 32'(busy),      32'd0);
    check("rst_state",     -1, 32'(state_dbg), 32'(ST_LOAD));
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_cycle(vecs[i], i);

`ifdef PE_SEQ_STALL_EN
    // two stalled cycles at ctx 1: index frozen, ctx 1 reissued after release
    run_cycle(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd1), 200);
    run_cycle(v_run(2'd0, rows2[0], 1'b0, 1'b0, 1'b0, 1'b0), 201);
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0, 1'b1, ST_RUN), 202);
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1, ST_RUN), 203);
    run_cycle(v_run(2'd1, rows2[1], 1'b0, 1'b0, 1'b0, 1'b0), 204);
    run_cycle(v_run(2'd2, rows2[2], 1'b1, 1'b0, 1'b0, 1'b0), 205);
    run_cycle(v_run(2'd3, rows2[3], 1'b1, 1'b0, 1'b0, 1'b0), 206);
    run_cycle(v_drain(), 207);
    // stop during a stall still drains next cycle
    run_cycle(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd2), 208);
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, ST_RUN), 209);
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, ST_DRAIN), 210);
`else
    run_cycle(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd1), 200);
    for (int k = 0; k < 4; k++) run_cycle(v_run(2'(k), rows2[k], k > 0, 1'b0, 1'b0, 1'b0), 201 + k);
    run_cycle(v_drain(), 205);
`endif

    // reset asserted during RUN: LOAD next cycle, no done pulse
    run_cycle(v_ready(1'b0, 1'b0, 1'b1, 1'b0, 8'd3), 300);
    run_cycle(v_run(2'd0, rows2[0], 1'b0, 1'b0, 1'b0, 1'b0), 301);
    reset = 1'b1;
    run_cycle(v_run(2'd1, rows2[1], 1'b1, 1'b0, 1'b0, 1'b0), 302);
    reset = 1'b0;
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, ST_LOAD), 303);
    run_cycle(mkv(1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, ST_LOAD), 304);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pe_ctx_sequencer.md
# pe_ctx_sequencer

Configuration loader and context sequencer for a row of PEs. Accepts 8-bit PE control words over a valid/ready stream into an internal context store. On `start`, it replays the stored contexts cycle by cycle onto every PE's control input. Each PE control word is `{sel_op_0[2:0], sel_op_1[2:0], alu_op[1:0]}`. The block drives the shared PE enable and flags the cycles in which PE outputs are valid.

## Interface
Parameters:
- `NUM_PE`, 4: number of PEs driven; each gets one 8-bit control word per context.
- `NUM_CTX`, 4: number of stored contexts (power of two, ≥2).

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `cfg_valid`  in  1  config word present.
- `cfg_ready`  out  1  block accepts a config word this cycle.
- `cfg_data`  in  8  PE control word.
- `cfg_clear`  in  1  discard stored config and return to loading (honoured only in READY).
- `start`  in  1  begin replay (single-cycle pulse, honoured only in READY).
- `stop`  in  1  abort replay after the current cycle (honoured only in RUN).
- `iter_count`  in  8  number of full passes over all contexts; sampled when `start` is accepted.
- `pe_en`  out  1  enable to all PE control and operand registers.
- `pe_ctrl`  out  8*NUM_PE  control words; PE i uses bits [8i+7:8i].
- `ctx_idx`  out  $clog2(NUM_CTX)  context currently driven on `pe_ctrl`.
- `out_valid`  out  1  PE outputs reflect a context issued last cycle.
- `done`  out  1  one-cycle pulse when replay finishes or is aborted.
- `busy`  out  1  high in RUN and DRAIN.

## Operation
- States: LOAD, READY, RUN, DRAIN. Reset puts the block in LOAD.
- Reset clears the word counter, `ctx_idx`, the pass counter and all outputs to 0. Store contents are don't-care after reset and are overwritten before use.
- LOAD:
  - `cfg_ready`=1.
  - Each accepted word (`cfg_valid & cfg_ready`) is written to store[ctx][pe].
  - Write order is ctx 0 PE 0..NUM_PE-1, then ctx 1, and so on. The index is derived from a counter of width $clog2(NUM_CTX*NUM_PE).
  - After word NUM_CTX*NUM_PE-1 is accepted, go to READY. `cfg_ready` drops the next cycle.
- READY:
  - `cfg_ready`=0.
  - `start` with `iter_count`≠0 latches `iter_count` and goes to RUN with `ctx_idx`=0.
  - `start` with `iter_count`=0 is ignored; no `done` is produced.
  - `cfg_clear` resets the word counter and goes to LOAD.
  - If `start` and `cfg_clear` are asserted together, `cfg_clear` wins.
- RUN:
  - `pe_en`=1 and `pe_ctrl`=store[`ctx_idx`].
  - `ctx_idx` increments each cycle and wraps NUM_CTX-1 → 0. The pass counter increments on each wrap.
  - On the last context of the last pass, or when `stop` is asserted, go to DRAIN.
- DRAIN:
  - One cycle with `pe_en`=0 and `done`=1.
  - `ctx_idx` returns to 0 and the state returns to READY.
  - Stored config is retained, so `start` may be reissued without reloading.
- `pe_ctrl` is all zeros whenever `pe_en`=0.
- `out_valid` is `pe_en` delayed by one register stage.
- Inputs not honoured in the current state are ignored: `start` outside READY, `stop` outside RUN, `cfg_valid` outside LOAD.

## Timing
- Config load takes exactly NUM_CTX*NUM_PE accepted words. Back-to-back acceptance runs at 1 word per cycle.
- `start` accepted at cycle T gives RUN cycles T+1 … T+P, where P = `iter_count`*NUM_CTX. DRAIN (`done`=1) is at T+P+1.
- `out_valid` is high over cycles T+2 … T+P+1.
- `stop` sampled at RUN cycle S: cycle S still issues its context, and DRAIN is at S+1. `out_valid` covers the last issued context at S+1.
- `busy`=1 from T+1 through DRAIN inclusive.
- Reset asserted mid-RUN: the next cycle is LOAD with all outputs 0 and no `done` pulse.

## Configuration
- `PE_SEQ_STALL_EN` defined: adds input port `stall` (1 bit).
  - In RUN, `stall`=1 forces `pe_en`=0 and `pe_ctrl`=0, and freezes `ctx_idx` and the pass counter.
  - `out_valid` follows the delayed `pe_en` as usual.
  - `stop` during a stall still goes to DRAIN next cycle.
  - `stall` has no effect outside RUN.
- Not defined: no `stall` port; RUN issues exactly one context per cycle unconditionally.

## Test plan
- Reset then load 16 words 0x00..0x0F with `cfg_valid` held (NUM_PE=4, NUM_CTX=4) → `cfg_ready` high 16 cycles then low. State READY; `pe_en`=0, `pe_ctrl`=0.
- After load, `start` with `iter_count`=2 → 8 RUN cycles. `pe_ctrl` = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, repeated twice. `ctx_idx` 0,1,2,3,0,1,2,3. `out_valid` lags `pe_en` by one cycle; single `done` in cycle 9.
- `start` with `iter_count`=0 → no RUN, no `done`. `start` during LOAD → ignored, loading continues.
- `stop` at the 3rd RUN cycle (`iter_count`=5) → DRAIN next cycle, `done`=1, back to READY. A re-`start` with `iter_count`=1 replays from ctx 0 without reload.
- `cfg_clear` and `start` together in READY → LOAD, `cfg_ready`=1, no RUN. Reset asserted during RUN → LOAD next cycle, outputs 0, no `done`.
- With `PE_SEQ_STALL_EN`: `stall` for 2 cycles at ctx 1 → `pe_en` low for 2 cycles, ctx 1 reissued after release, total RUN length extended by 2 cycles.
